decode: RTL and testbench

DECODE -- requirements
Module: decode

---
 rtl/cpu_defs.sv | 49 ++++
 rtl/regfile.sv | 36 +++
 rtl/decode.sv | 152 +++++++++++++++
 tb/tb_decode.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared ISA encodings and decode-stage bundle, reused by decode and execute.
package cpu_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4
  } alu_op_e;

  // Everything the decode stage hands to execute; all-zero is a bubble.
  typedef struct packed {
    logic [31:0] npc;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    alu_op_e     alu_op;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } id_bundle_t;

  // Instructions whose rt field is a source operand (not a destination).
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file, r0 hardwired to zero, write-through bypass on reads.
module regfile
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] mem [32];

  // Storage: cleared by reset, r0 never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      mem[wa] <= wd;
    end
  end

  // Read ports: a write landing this edge is forwarded so decode sees new data.
  always_comb begin
    rd1 = mem[ra1];
    rd2 = mem[ra2];
    if (we && (wa == ra1)) rd1 = wd;
    if (we && (wa == ra2)) rd2 = wd;
    if (ra1 == 5'd0) rd1 = '0;
    if (ra2 == 5'd0) rd2 = '0;
  end

endmodule

// File: rtl/decode.sv
// Decode stage: field extraction, control generation, load-use stall, ID register.
module decode
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir_if,
  input  logic [31:0] npc_if,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic [31:0] npc_id,
  output logic [31:0] rs_val_id,
  output logic [31:0] rt_val_id,
  output logic [31:0] imm_id,
  output logic [4:0]  rs_id,
  output logic [4:0]  rt_id,
  output logic [4:0]  dst_id,
  output logic [3:0]  alu_op_id,
  output logic        alu_src_id,
  output logic        reg_write_id,
  output logic        mem_read_id,
  output logic        mem_write_id,
  output logic        branch_id,
  output logic        jump_id,
  output logic        illegal_id
);

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        legal;
  id_bundle_t  dec;
  id_bundle_t  nxt;
  id_bundle_t  q;

  assign op    = ir_if[31:26];
  assign rs    = ir_if[25:21];
  assign rt    = ir_if[20:16];
  assign rd    = ir_if[15:11];
  assign funct = ir_if[5:0];

  regfile u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rs_val),
    .rd2 (rt_val),
    .we  (wb_we),
    .wa  (wb_addr),
    .wd  (wb_data)
  );

  // Load-use hazard against the load now sitting in the ID register.
  // Reset and flush both kill it; flush wins because the stalled slot is dead.
  always_comb begin
    stall = 1'b0;
    if (!rst && !flush && q.mem_read && (q.dst != 5'd0)) begin
      stall = (q.dst == rs) || ((q.dst == rt) && reads_rt(op));
    end
  end

  // Instruction decode and bubble selection for the next ID contents.
  always_comb begin
    dec        = '0;
    legal      = 1'b1;
    dec.npc    = npc_if;
    dec.rs_val = rs_val;
    dec.rt_val = rt_val;
    dec.rs     = rs;
    dec.rt     = rt;
    dec.imm    = {{16{ir_if[15]}}, ir_if[15:0]};
    case (op)
      OP_RTYPE: begin
        dec.dst       = rd;
        dec.reg_write = 1'b1;
        case (funct)
          FN_ADD:  dec.alu_op = ALU_ADD;
          FN_SUB:  dec.alu_op = ALU_SUB;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_SLT:  dec.alu_op = ALU_SLT;
          default: legal      = 1'b0;
        endcase
      end
      OP_ADDI: begin
        dec.dst       = rt;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_LW: begin
        dec.dst       = rt;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_SW: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
      end
      OP_J: begin
        dec.jump = 1'b1;
        dec.imm  = {6'b0, ir_if[25:0]};
      end
      default: legal = 1'b0;
    endcase

    nxt = dec;
    // All-zero word is the canonical NOP; held/killed slots become bubbles.
    // An illegal word held by a stall is flagged when it is actually issued.
    if (flush || stall || (ir_if == 32'd0)) begin
      nxt = '0;
    end else if (!legal) begin
      nxt         = '0;
      nxt.illegal = 1'b1;
    end
  end

  // ID pipeline register.
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= nxt;
  end

  assign npc_id       = q.npc;
  assign rs_val_id    = q.rs_val;
  assign rt_val_id    = q.rt_val;
  assign imm_id       = q.imm;
  assign rs_id        = q.rs;
  assign rt_id        = q.rt;
  assign dst_id       = q.dst;
  assign alu_op_id    = q.alu_op;
  assign alu_src_id   = q.alu_src;
  assign reg_write_id = q.reg_write;
  assign mem_read_id  = q.mem_read;
  assign mem_write_id = q.mem_write;
  assign branch_id    = q.branch;
  assign jump_id      = q.jump;
  assign illegal_id   = q.illegal;

endmodule

// File: tb/tb_decode.sv
// Decode-stage bench: directed scenarios plus random instruction stream vs model.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir_if;
  logic [31:0] npc_if;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall;
  logic [31:0] npc_id, rs_val_id, rt_val_id, imm_id;
  logic [4:0]  rs_id, rt_id, dst_id;
  logic [3:0]  alu_op_id;
  logic        alu_src_id, reg_write_id, mem_read_id, mem_write_id;
  logic        branch_id, jump_id, illegal_id;

  always #5 clk = ~clk;

  decode dut (
    .clk(clk), .rst(rst), .ir_if(ir_if), .npc_if(npc_if), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall),
    .npc_id(npc_id), .rs_val_id(rs_val_id), .rt_val_id(rt_val_id),
    .imm_id(imm_id), .rs_id(rs_id), .rt_id(rt_id), .dst_id(dst_id),
    .alu_op_id(alu_op_id), .alu_src_id(alu_src_id),
    .reg_write_id(reg_write_id), .mem_read_id(mem_read_id),
    .mem_write_id(mem_write_id), .branch_id(branch_id), .jump_id(jump_id),
    .illegal_id(illegal_id)
  );

  typedef struct {
    logic [31:0] npc, rsv, rtv, imm;
    logic [4:0]  rs, rt, dst;
    logic [3:0]  aop;
    logic        asrc, rw, mr, mw, br, jp, ill;
  } exp_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] regs [32];
  exp_t        cur;
  logic        obs_stall;
  logic        exp_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t bubble();
    exp_t b;
    b = '{npc:0, rsv:0, rtv:0, imm:0, rs:0, rt:0, dst:0, aop:0,
          asrc:0, rw:0, mr:0, mw:0, br:0, jp:0, ill:0};
    return b;
  endfunction

  // Spec-level meaning of one instruction word, given register contents.
  function automatic exp_t model(input logic [31:0] ir, input logic [31:0] npc,
                                 input logic kill);
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    logic ok;
    op = ir[31:26];
    fn = ir[5:0];
    e = bubble();
    if (kill || ir == 32'd0) return e;
    ok = 1'b1;
    e.npc = npc;
    e.rs  = ir[25:21];
    e.rt  = ir[20:16];
    e.rsv = regs[ir[25:21]];
    e.rtv = regs[ir[20:16]];
    e.imm = 32'($signed(ir[15:0]));
    if (op == 6'h00) begin
      e.dst = ir[15:11]; e.rw = 1;
      if      (fn == 6'h20) e.aop = 0;
      else if (fn == 6'h22) e.aop = 1;
      else if (fn == 6'h24) e.aop = 2;
      else if (fn == 6'h25) e.aop = 3;
      else if (fn == 6'h2a) e.aop = 4;
      else ok = 0;
    end else if (op == 6'h08) begin e.dst = ir[20:16]; e.rw = 1; e.asrc = 1;
    end else if (op == 6'h23) begin e.dst = ir[20:16]; e.rw = 1; e.asrc = 1; e.mr = 1;
    end else if (op == 6'h2b) begin e.mw = 1; e.asrc = 1;
    end else if (op == 6'h04) begin e.br = 1; e.aop = 1;
    end else if (op == 6'h02) begin e.jp = 1; e.imm = {6'b0, ir[25:0]};
    end else ok = 0;
    if (!ok) begin e = bubble(); e.ill = 1; end
    return e;
  endfunction

  // One clock: drive inputs, check stall, update model, check ID after the edge.
  task automatic step(input logic r, input logic [31:0] ir, input logic [31:0] npc,
                      input logic fl, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd);
    exp_t nx;
    logic [5:0] op;
    rst = r; ir_if = ir; npc_if = npc; flush = fl;
    wb_we = we; wb_addr = wa; wb_data = wd;
    op = ir[31:26];
    #1;
    exp_stall = !r && !fl && cur.mr && cur.dst != 0 &&
                (cur.dst == ir[25:21] ||
                 (cur.dst == ir[20:16] && (op == 6'h00 || op == 6'h2b || op == 6'h04)));
    obs_stall = stall;
    chk("stall", 32'(stall), 32'(exp_stall));
    if (r) begin
      for (int i = 0; i < 32; i++) regs[i] = 0;
      nx = bubble();
    end else begin
      if (we && wa != 0) regs[wa] = wd;
      nx = model(ir, npc, fl || exp_stall);
    end
    @(posedge clk); #1;
    chk("npc_id",    npc_id,    nx.npc);
    chk("rs_val_id", rs_val_id, nx.rsv);
    chk("rt_val_id", rt_val_id, nx.rtv);
    chk("imm_id",    imm_id,    nx.imm);
    chk("rs_id",     32'(rs_id),  32'(nx.rs));
    chk("rt_id",     32'(rt_id),  32'(nx.rt));
    chk("dst_id",    32'(dst_id), 32'(nx.dst));
    chk("alu_op_id", 32'(alu_op_id), 32'(nx.aop));
    chk("ctrl", {25'd0, alu_src_id, reg_write_id, mem_read_id, mem_write_id,
                 branch_id, jump_id, illegal_id},
                {25'd0, nx.asrc, nx.rw, nx.mr, nx.mw, nx.br, nx.jp, nx.ill});
    cur = nx;
  endtask

  task automatic idle(input logic [31:0] ir);
    step(1'b0, ir, 32'h100, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  localparam logic [31:0] LW_R2 = {6'h23, 5'd1, 5'd2, 16'd4};
  localparam logic [31:0] ADD_R4 = {6'h00, 5'd2, 5'd2, 5'd4, 5'd0, 6'h20};

  initial begin
    logic [31:0] ir, npc, hold_ir, hold_npc;
    logic [5:0]  fn_tab [6];
    logic [5:0]  op_tab [8];
    logic        held;
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};
    op_tab = '{6'h00, 6'h08, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h3f, 6'h00};
    cur = bubble();
    for (int i = 0; i < 32; i++) regs[i] = 0;
    rst = 1; ir_if = 0; npc_if = 0; flush = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
    @(posedge clk); #1;

    // Reset for two cycles with garbage inputs, then everything reads zero.
    step(1'b1, ADD_R4, 32'h55, 1'b0, 1'b1, 5'd9, 32'hFFFF);
    step(1'b1, LW_R2, 32'h66, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("rst_illegal", 32'(illegal_id), 32'd0);
    for (int i = 1; i < 32; i++) begin
      idle({6'h00, 5'(i), 5'(i), 5'd1, 5'd0, 6'h20});
      chk("rst_regs", rs_val_id | rt_val_id, 32'd0);
    end

    // Write r5 then ADD r3,r5,r0.
    step(1'b0, 32'd0, 32'h10, 1'b0, 1'b1, 5'd5, 32'h1234);
    idle({6'h00, 5'd5, 5'd0, 5'd3, 5'd0, 6'h20});
    chk("add_rs_val", rs_val_id, 32'h1234);
    chk("add_dst", 32'(dst_id), 32'd3);

    // Load-use: one stall, bubble, then ADD issues.
    idle(LW_R2);
    idle(ADD_R4);
    chk("lu_stall", 32'(obs_stall), 32'd1);
    chk("lu_bubble", 32'(reg_write_id), 32'd0);
    idle(ADD_R4);
    chk("lu_stall_once", 32'(obs_stall), 32'd0);
    chk("lu_rs_id", 32'(rs_id), 32'd2);

    // Bypass: write r7 in the same cycle as ADDI r8,r7,-1.
    step(1'b0, {6'h08, 5'd7, 5'd8, 16'hFFFF}, 32'h20, 1'b0, 1'b1, 5'd7, 32'hAA);
    chk("byp_rs_val", rs_val_id, 32'hAA);
    chk("byp_imm", imm_id, 32'hFFFF_FFFF);

    // Flush overrides a load-use stall.
    idle(LW_R2);
    step(1'b0, ADD_R4, 32'h30, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("fl_stall", 32'(obs_stall), 32'd0);
    idle(ADD_R4);
    chk("fl_next_dst", 32'(dst_id), 32'd4);

    // Reset during a stall drops the hazard.
    idle(LW_R2);
    step(1'b1, ADD_R4, 32'h40, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("rst_stall", 32'(obs_stall), 32'd0);

    // Illegal opcode for one cycle; r0 stays zero.
    idle({6'h3f, 26'h123});
    chk("ill_flag", 32'(illegal_id), 32'd1);
    step(1'b0, 32'd0, 32'h50, 1'b0, 1'b1, 5'd0, 32'hDEAD);
    chk("ill_one_cycle", 32'(illegal_id), 32'd0);
    idle({6'h00, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20});
    chk("r0_zero", rs_val_id, 32'd0);

    // Random stream; fetch holds the word while the model predicts a stall.
    held = 0; hold_ir = 0; hold_npc = 0;
    for (int n = 0; n < 600; n++) begin
      if (held) begin
        ir = hold_ir; npc = hold_npc;
      end else begin
        ir  = $urandom;
        npc = $urandom;
        ir[31:26] = op_tab[$urandom_range(0, 7)];
        ir[25:21] = 5'($urandom_range(0, 7));
        ir[20:16] = 5'($urandom_range(0, 7));
        ir[15:11] = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 9) != 0) ir[5:0] = fn_tab[$urandom_range(0, 5)];
        if ($urandom_range(0, 19) == 0) ir = 0;
      end
      step(($urandom_range(0, 99) == 0), ir, npc, ($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      held = exp_stall; hold_ir = ir; hold_npc = npc;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
